vcve2_rf_wr_arbiter: RTL and testbench

Shares the single scalar register-file write port between three producers: ID/EX results, LSU load data, and scalar results returned by the vector unit (e.g. `vmv.x.s`, `vcpop`).
The block sits between the execute/LSU/vector sources and the writeback passthrough, and it drives that passthrough's RF write port.
Vector results are decoupled through a small FIFO.
Starvation of the vector source is bounded by an age counter that briefly stalls ID.

---
 rtl/vcve2_rf_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_vcve2_rf_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_rf_wr_arbiter.sv
// vcve2_rf_wr_arbiter: shares the scalar register-file write port among
// ID/EX results, LSU load data and scalar results returned by the vector
// unit. Vector results are queued in a small FIFO. An age counter bounds how
// long the FIFO head can be held off by ID writes.
module vcve2_rf_wr_arbiter #(
  parameter int unsigned VecFifoDepth = 2,
  parameter int unsigned StarveLimit  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  rf_we_id_i,
  input  logic [4:0]                            rf_waddr_id_i,
  input  logic [31:0]                           rf_wdata_id_i,
  input  logic                                  rf_we_lsu_i,
  input  logic [4:0]                            rf_waddr_lsu_i,
  input  logic [31:0]                           rf_wdata_lsu_i,
  input  logic                                  vec_valid_i,
  output logic                                  vec_ready_o,
  input  logic [4:0]                            vec_waddr_i,
  input  logic [31:0]                           vec_wdata_i,
  output logic                                  rf_we_o,
  output logic [4:0]                            rf_waddr_o,
  output logic [31:0]                           rf_wdata_o,
  output logic                                  id_stall_o,
  output logic [$clog2(VecFifoDepth+1)-1:0]     vec_count_o
);

  localparam int unsigned PtrW = (VecFifoDepth > 1) ? $clog2(VecFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(VecFifoDepth + 1);
  localparam int unsigned StW  = $clog2(StarveLimit + 1);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;

  // FIFO payload storage carries no reset; occupancy alone decides validity.
  logic [4:0]  addr_mem_q [VecFifoDepth];
  logic [31:0] data_mem_q [VecFifoDepth];

  logic fifo_empty;
  logic starve_max;
  logic grant_lsu;
  logic grant_vec;
  logic grant_id;
  logic push_store;

  assign fifo_empty  = (count_q == '0);
  assign starve_max  = (starve_q == StW'(StarveLimit));
  // No pop-to-push bypass: a full FIFO refuses pushes for the whole cycle.
  assign vec_ready_o = (count_q != CntW'(VecFifoDepth));
  // Writes to x0 complete the handshake but are dropped here.
  assign push_store  = vec_valid_i & vec_ready_o & (vec_waddr_i != 5'd0);
  assign vec_count_o = count_q;

  // Fixed-priority grant: LSU, then vector (when ID is idle or the head is starved), then ID.
  always_comb begin
    grant_lsu = rf_we_lsu_i;
    grant_vec = ~grant_lsu & ~fifo_empty & (starve_max | ~rf_we_id_i);
    grant_id  = ~grant_lsu & ~grant_vec & rf_we_id_i;
  end

  assign id_stall_o = rf_we_id_i & ~grant_id;

  // Route the granted source to the RF write port; zeros when nothing is granted.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (grant_lsu) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = rf_waddr_lsu_i;
      rf_wdata_o = rf_wdata_lsu_i;
    end else if (grant_vec) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = addr_mem_q[rptr_q];
      rf_wdata_o = data_mem_q[rptr_q];
    end else if (grant_id) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = rf_waddr_id_i;
      rf_wdata_o = rf_wdata_id_i;
    end
  end

  // Next-state for FIFO pointers, occupancy and the starvation counter.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (push_store) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (grant_vec) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push_store, grant_vec})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (grant_vec || fifo_empty) begin
      starve_d = '0;
    end else if (!starve_max) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Payload write into the slot at the write pointer.
  always_ff @(posedge clk_i) begin
    if (push_store) begin
      addr_mem_q[wptr_q] <= vec_waddr_i;
      data_mem_q[wptr_q] <= vec_wdata_i;
    end
  end

  // LSU writebacks cannot stall, so the pipeline must never overlap them with ID writes.
  no_lsu_id_overlap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rf_we_lsu_i && rf_we_id_i));

endmodule

// File: tb/tb_vcve2_rf_wr_arbiter.sv
// Testbench for vcve2_rf_wr_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference of the arbiter.
module tb_vcve2_rf_wr_arbiter;

  localparam int Depth = 2;
  localparam int Limit = 4;
  localparam int CntW  = $clog2(Depth + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rst_req;
  logic            rf_we_id;
  logic [4:0]      rf_waddr_id;
  logic [31:0]     rf_wdata_id;
  logic            rf_we_lsu;
  logic [4:0]      rf_waddr_lsu;
  logic [31:0]     rf_wdata_lsu;
  logic            vec_valid;
  logic            vec_ready;
  logic [4:0]      vec_waddr;
  logic [31:0]     vec_wdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            id_stall;
  logic [CntW-1:0] vec_count;

  always #5 clk = ~clk;

  vcve2_rf_wr_arbiter #(
    .VecFifoDepth(Depth),
    .StarveLimit (Limit)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rf_we_id_i    (rf_we_id),
    .rf_waddr_id_i (rf_waddr_id),
    .rf_wdata_id_i (rf_wdata_id),
    .rf_we_lsu_i   (rf_we_lsu),
    .rf_waddr_lsu_i(rf_waddr_lsu),
    .rf_wdata_lsu_i(rf_wdata_lsu),
    .vec_valid_i   (vec_valid),
    .vec_ready_o   (vec_ready),
    .vec_waddr_i   (vec_waddr),
    .vec_wdata_i   (vec_wdata),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .id_stall_o    (id_stall),
    .vec_count_o   (vec_count)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        stall;
    logic        rdy;
    int          cnt;
  } rec_t;

  ent_t mq[$];   // reference vector FIFO contents
  rec_t sb[$];   // expected port values per cycle
  int   m_starve = 0;
  int   n_vec    = 0;
  int   n_bad    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, predict, compare 1ns later, update reference after posedge.
  task automatic step(input logic idw, input logic [4:0] ida, input logic [31:0] idd,
                      input logic lw, input logic [4:0] la, input logic [31:0] ld,
                      input logic vv, input logic [4:0] va, input logic [31:0] vd,
                      output rec_t o, output logic hs);
    rec_t e, x;
    logic gl, gv, gi, was_empty;
    @(negedge clk);
    rst_n        = rst_req;
    rf_we_id     = idw;  rf_waddr_id  = ida; rf_wdata_id  = idd;
    rf_we_lsu    = lw;   rf_waddr_lsu = la;  rf_wdata_lsu = ld;
    vec_valid    = vv;   vec_waddr    = va;  vec_wdata    = vd;
    gl = lw;
    gv = !gl && (mq.size() != 0) && ((m_starve == Limit) || !idw);
    gi = !gl && !gv && idw;
    e.we = gl | gv | gi;
    e.a  = 5'd0;
    e.d  = 32'd0;
    if (gl) begin
      e.a = la; e.d = ld;
    end else if (gv) begin
      e.a = mq[0].a; e.d = mq[0].d;
    end else if (gi) begin
      e.a = ida; e.d = idd;
    end
    e.stall = idw && !gi;
    e.rdy   = (mq.size() != Depth);
    e.cnt   = mq.size();
    sb.push_back(e);
    #1;
    o.we = rf_we; o.a = rf_waddr; o.d = rf_wdata;
    o.stall = id_stall; o.rdy = vec_ready; o.cnt = int'(vec_count);
    x = sb.pop_front();
    chk("rf_we",    32'(o.we),    32'(x.we));
    chk("rf_waddr", 32'(o.a),     32'(x.a));
    chk("rf_wdata", o.d,          x.d);
    chk("id_stall", 32'(o.stall), 32'(x.stall));
    chk("vec_rdy",  32'(o.rdy),   32'(x.rdy));
    chk("vec_cnt",  32'(o.cnt),   32'(x.cnt));
    hs = vv && x.rdy;
    was_empty = (mq.size() == 0);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_starve = 0;
    end else begin
      if (gv) void'(mq.pop_front());
      if (hs && va != 5'd0) mq.push_back('{a: va, d: vd});
      if (gv || was_empty) m_starve = 0;
      else if (m_starve < Limit) m_starve++;
    end
  endtask

  rec_t o;
  logic hs;
  int   tries;

  initial begin
    rst_n = 1'b0; rst_req = 1'b0;
    rf_we_id = 0; rf_waddr_id = 0; rf_wdata_id = 0;
    rf_we_lsu = 0; rf_waddr_lsu = 0; rf_wdata_lsu = 0;
    vec_valid = 0; vec_waddr = 0; vec_wdata = 0;
    @(posedge clk);
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    rst_req = 1'b1;
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    chk("rst_cnt", 32'(o.cnt), 0);
    chk("rst_rdy", 32'(o.rdy), 1);
    chk("rst_we",  32'(o.we), 0);
    chk("rst_stall", 32'(o.stall), 0);

    // Idle vector path
    step(0,0,0, 0,0,0, 1,5'd5,32'hDEADBEEF, o, hs);
    chk("idle_hs", 32'(hs), 1);
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    chk("idle_we", 32'(o.we), 1);
    chk("idle_a",  32'(o.a), 5);
    chk("idle_d",  o.d, 32'hDEADBEEF);
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    chk("idle_cnt0", 32'(o.cnt), 0);

    // Full FIFO under continuous ID writes
    step(1,5'd9,32'h900, 0,0,0, 1,5'd1,32'h11, o, hs);
    step(1,5'd9,32'h901, 0,0,0, 1,5'd2,32'h22, o, hs);
    tries = 0;
    hs = 1'b0;
    while (!hs && tries < 10) begin
      step(1,5'd9,32'h910 + tries, 0,0,0, 1,5'd3,32'h33, o, hs);
      tries++;
      if (tries == 1) begin
        chk("full_cnt", 32'(o.cnt), 2);
        chk("full_rdy", 32'(o.rdy), 0);
      end
      if (tries == 4) begin
        chk("full_pop_a", 32'(o.a), 1);
        chk("full_pop_d", o.d, 32'h11);
        chk("full_pop_stall", 32'(o.stall), 1);
        chk("full_pop_rdy", 32'(o.rdy), 0);
      end
    end
    chk("full_tries", 32'(tries), 5);
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    chk("drain_a2", 32'(o.a), 2);
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    chk("drain_a3", 32'(o.a), 3);

    // Starvation bound
    step(1,5'd9,32'h99, 0,0,0, 1,5'd4,32'h44, o, hs);
    for (int i = 0; i < 4; i++) begin
      step(1,5'd9,32'h99, 0,0,0, 0,0,0, o, hs);
      chk("starve_id_a", 32'(o.a), 9);
      chk("starve_id_stall", 32'(o.stall), 0);
    end
    step(1,5'd9,32'h99, 0,0,0, 0,0,0, o, hs);
    chk("forced_a", 32'(o.a), 4);
    chk("forced_d", o.d, 32'h44);
    chk("forced_stall", 32'(o.stall), 1);
    step(1,5'd9,32'h99, 0,0,0, 0,0,0, o, hs);
    chk("post_forced_a", 32'(o.a), 9);
    chk("post_forced_stall", 32'(o.stall), 0);

    // LSU priority while starve counter is at its limit
    step(1,5'd9,32'h99, 0,0,0, 1,5'd4,32'h44, o, hs);
    for (int i = 0; i < 4; i++) step(1,5'd9,32'h99, 0,0,0, 0,0,0, o, hs);
    step(0,0,0, 1,5'd7,32'h1234, 0,0,0, o, hs);
    chk("lsu_a", 32'(o.a), 7);
    chk("lsu_d", o.d, 32'h1234);
    chk("lsu_cnt", 32'(o.cnt), 1);
    step(1,5'd9,32'h99, 0,0,0, 0,0,0, o, hs);
    chk("after_lsu_a", 32'(o.a), 4);
    chk("after_lsu_stall", 32'(o.stall), 1);

    // x0 push is accepted but dropped
    step(0,0,0, 0,0,0, 1,5'd0,32'hFFFF_FFFF, o, hs);
    chk("x0_hs", 32'(hs), 1);
    for (int i = 0; i < 3; i++) begin
      step(0,0,0, 0,0,0, 0,0,0, o, hs);
      chk("x0_we", 32'(o.we), 0);
      chk("x0_cnt", 32'(o.cnt), 0);
    end

    // Random traffic with no LSU/ID overlap
    for (int i = 0; i < 80; i++) begin
      int unsigned src;
      src = $urandom_range(0, 3);
      step(src == 1 || src == 3, 5'($urandom_range(1, 31)), $urandom,
           src == 2, 5'($urandom_range(1, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, o, hs);
    end
    for (int i = 0; i < 4; i++) step(0,0,0, 0,0,0, 0,0,0, o, hs);

    // Reset with a full FIFO
    step(1,5'd9,32'h99, 0,0,0, 1,5'd1,32'h11, o, hs);
    step(1,5'd9,32'h99, 0,0,0, 1,5'd2,32'h22, o, hs);
    rst_req = 1'b0;
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    chk("prerst_cnt", 32'(o.cnt), 2);
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    rst_req = 1'b1;
    step(0,0,0, 0,0,0, 0,0,0, o, hs);
    chk("midrst_cnt", 32'(o.cnt), 0);
    chk("midrst_rdy", 32'(o.rdy), 1);
    chk("midrst_we", 32'(o.we), 0);
    chk("midrst_stall", 32'(o.stall), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
